// File: rtl/id_queue.sv
// rtl/id_queue.sv - decode-stage instruction queue with load-use stall and issue register; ID_BRANCH_RESOLVE_EN adds branch resolution
module id_queue #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int PC_STEP = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_valid_i,
  output logic                     if_ready_o,
  input  logic [31:0]              if_inst_i,
  input  logic [XLEN-1:0]          if_pc_i,
  input  logic                     flush_i,
  output logic [4:0]               rf_rs1_addr_o,
  output logic [4:0]               rf_rs2_addr_o,
  input  logic [XLEN-1:0]          rf_rs1_data_i,
  input  logic [XLEN-1:0]          rf_rs2_data_i,
  input  logic [4:0]               ex_rd_addr_i,
  input  logic                     ex_is_load_i,
  input  logic                     ex_ready_i,
  output logic                     id_valid_o,
  output logic [31:0]              id_inst_o,
  output logic [XLEN-1:0]          id_pc_o,
  output logic [XLEN-1:0]          id_pc_plus_o,
  output logic [XLEN-1:0]          id_imm_o,
  output logic [XLEN-1:0]          id_rs1_data_o,
  output logic [XLEN-1:0]          id_rs2_data_o,
  output logic [4:0]               id_rd_addr_o,
  output logic [2:0]               id_funct3_o,
  output logic                     hazard_stall_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     branch_taken_o,
  output logic [XLEN-1:0]          branch_addr_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Queue storage and bookkeeping
  logic [31:0]     r_inst_mem [DEPTH];
  logic [XLEN-1:0] r_pc_mem   [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  // Issued bundle
  logic            r_id_valid;
  logic [31:0]     r_id_inst;
  logic [XLEN-1:0] r_id_pc;
  logic [XLEN-1:0] r_id_pc_plus;
  logic [XLEN-1:0] r_id_imm;
  logic [XLEN-1:0] r_id_rs1_data;
  logic [XLEN-1:0] r_id_rs2_data;
  logic [4:0]      r_id_rd_addr;
  logic [2:0]      r_id_funct3;

  logic            w_empty;
  logic [31:0]     w_head_inst;
  logic [XLEN-1:0] w_head_pc;
  logic [XLEN-1:0] w_imm;
  logic            w_hazard;
  logic            w_push;
  logic            w_out_free;
  logic            w_issue;
  logic            w_redirect;

  // Sign-extended immediate of the head instruction, selected by opcode format
  function automatic logic [XLEN-1:0] f_imm(input logic [31:0] inst);
    logic signed [31:0] v;
    v = '0;
    case (inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR: v = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:                 v = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:                v = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         v = {inst[31:12], 12'b0};
      OP_JAL:                   v = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:                  v = '0;
    endcase
    return XLEN'(v);
  endfunction

  assign w_empty     = (r_count == '0);
  assign w_head_inst = r_inst_mem[r_rd_ptr];
  assign w_head_pc   = r_pc_mem[r_rd_ptr];
  assign w_imm       = f_imm(w_head_inst);

  assign rf_rs1_addr_o = w_empty ? 5'd0 : w_head_inst[19:15];
  assign rf_rs2_addr_o = w_empty ? 5'd0 : w_head_inst[24:20];

  // Load-use: the head would read a register the EX-stage load has not produced yet
  assign w_hazard = !w_empty && ex_is_load_i && (ex_rd_addr_i != 5'd0) &&
                    ((ex_rd_addr_i == w_head_inst[19:15]) || (ex_rd_addr_i == w_head_inst[24:20]));
  assign hazard_stall_o = w_hazard;

  // Fullness is judged on the registered count only; a same-cycle pop does not free a slot
  assign if_ready_o = (r_count < DEPTH_C) && !flush_i;
  assign w_push     = if_valid_i && if_ready_o;
  assign w_out_free = !r_id_valid || ex_ready_i;
  assign w_issue    = w_out_free && !w_empty && !w_hazard && !flush_i;

`ifdef ID_BRANCH_RESOLVE_EN
  logic            r_branch_taken;
  logic [XLEN-1:0] r_branch_addr;

  // Conditional branch outcome on the operands being captured; JAL always redirects
  function automatic logic f_br_taken(input logic [31:0] inst,
                                      input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
    logic t;
    t = 1'b0;
    if (inst[6:0] == OP_JAL) begin
      t = 1'b1;
    end else if (inst[6:0] == OP_BRANCH) begin
      case (inst[14:12])
        3'b000:  t = (a == b);
        3'b001:  t = (a != b);
        3'b100:  t = ($signed(a) <  $signed(b));
        3'b101:  t = ($signed(a) >= $signed(b));
        3'b110:  t = (a <  b);
        3'b111:  t = (a >= b);
        default: t = 1'b0;
      endcase
    end
    return t;
  endfunction

  assign w_redirect = w_issue && f_br_taken(w_head_inst, rf_rs1_data_i, rf_rs2_data_i);

  // One-cycle redirect pulse; target is kept until the next taken branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_taken <= 1'b0;
      r_branch_addr  <= '0;
    end else if (flush_i) begin
      r_branch_taken <= 1'b0;
    end else begin
      r_branch_taken <= w_redirect;
      if (w_redirect) begin
        r_branch_addr <= w_head_pc + w_imm;
      end
    end
  end

  assign branch_taken_o = r_branch_taken;
  assign branch_addr_o  = r_branch_addr;
`else
  assign w_redirect     = 1'b0;
  assign branch_taken_o = 1'b0;
  assign branch_addr_o  = '0;
`endif

  // Write accepted fetches into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst_mem[r_wr_ptr] <= if_inst_i;
      r_pc_mem[r_wr_ptr]   <= if_pc_i;
    end
  end

  // Pointer and occupancy tracking; flush or a taken redirect drops everything queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i || w_redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_issue);
    end
  end

  // Issue register: loads the head when the slot is free, otherwise holds the bundle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_valid    <= 1'b0;
      r_id_inst     <= '0;
      r_id_pc       <= '0;
      r_id_pc_plus  <= '0;
      r_id_imm      <= '0;
      r_id_rs1_data <= '0;
      r_id_rs2_data <= '0;
      r_id_rd_addr  <= '0;
      r_id_funct3   <= '0;
    end else if (flush_i) begin
      r_id_valid <= 1'b0;
    end else if (w_out_free) begin
      r_id_valid <= w_issue;
      if (w_issue) begin
        r_id_inst     <= w_head_inst;
        r_id_pc       <= w_head_pc;
        r_id_pc_plus  <= w_head_pc + XLEN'(PC_STEP);
        r_id_imm      <= w_imm;
        r_id_rs1_data <= rf_rs1_data_i;
        r_id_rs2_data <= rf_rs2_data_i;
        r_id_rd_addr  <= w_head_inst[11:7];
        r_id_funct3   <= w_head_inst[14:12];
      end
    end
  end

  assign id_valid_o    = r_id_valid;
  assign id_inst_o     = r_id_inst;
  assign id_pc_o       = r_id_pc;
  assign id_pc_plus_o  = r_id_pc_plus;
  assign id_imm_o      = r_id_imm;
  assign id_rs1_data_o = r_id_rs1_data;
  assign id_rs2_data_o = r_id_rs2_data;
  assign id_rd_addr_o  = r_id_rd_addr;
  assign id_funct3_o   = r_id_funct3;
  assign count_o       = r_count;

endmodule
